// File: rtl/tt_scan_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
package tt_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    function automatic int unsigned combos(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Position of resp[o] captured at stim=i inside tt_out.
    function automatic int unsigned tt_bit(input int unsigned o, input int unsigned i,
                                           input int unsigned n_in);
        return o * combos(n_in) + i;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Stimulus/capture bus between the scanner and its driver/consumer.
// TT_EXPECT_CHECK_EN adds the expected-table compare signals.
interface truth_table_scanner_if
    import tt_scan_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 3
);
    localparam int unsigned TT_W = N_OUT * combos(N_IN);

    logic             start;
    logic [N_IN-1:0]  stim;
    logic [N_OUT-1:0] resp;
    logic             busy;
    logic             done;
    logic [TT_W-1:0]  tt_out;

`ifdef TT_EXPECT_CHECK_EN
    logic [TT_W-1:0]  exp_tt;
    logic             mismatch;
    logic [N_IN-1:0]  mismatch_idx;

    modport master (output start, resp, exp_tt,
                    input  stim, busy, done, tt_out, mismatch, mismatch_idx);
    modport slave  (input  start, resp, exp_tt,
                    output stim, busy, done, tt_out, mismatch, mismatch_idx);
`else
    modport master (output start, resp,
                    input  stim, busy, done, tt_out);
    modport slave  (input  start, resp,
                    output stim, busy, done, tt_out);
`endif

endinterface

// File: rtl/tt_settle_timer.sv
// Settle-time counter: cleared by load, advances while enabled, flags the last settle cycle.
module tt_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned W = $clog2(SETTLE_CYCLES) + 1;

    logic [W-1:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (load) begin
            settle_cnt <= '0;
        end else if (en) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign expired = (settle_cnt == W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all 2^N_IN stimulus combinations and captures the UUT response truth table.
// Optional TT_EXPECT_CHECK_EN: compare against exp_tt and latch the first mismatching index.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned N_OUT         = 3,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_scanner_if.slave bus
);
    localparam int unsigned   C    = combos(N_IN);
    localparam int unsigned   TT_W = N_OUT * C;
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(C - 1);

    state_t          state;
    logic [N_IN:0]   index;
    logic [N_IN-1:0] stim_q;
    logic            busy_q;
    logic            done_q;
    logic [TT_W-1:0] tt_q;
    logic [TT_W-1:0] tt_capt;
    logic            accept;
    logic            expired;

    assign accept = (state == IDLE) && bus.start;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept || (state == SAMPLE)),
        .en     (state == SETTLE),
        .expired(expired)
    );

    // Current table with the bits of the present index replaced by resp.
    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        for (genvar i = 0; i < C; i++) begin : g_comb
            localparam int unsigned B = tt_bit(o, i, N_IN);
            assign tt_capt[B] = (index[N_IN-1:0] == N_IN'(i)) ? bus.resp[o] : tt_q[B];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            index  <= '0;
            stim_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        index  <= '0;
                        stim_q <= '0;
                        tt_q   <= '0;
                        busy_q <= 1'b1;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (expired) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tt_q <= tt_capt;
                    if (index == LAST) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        index  <= index + 1'b1;
                        stim_q <= index[N_IN-1:0] + 1'b1;
                        state  <= SETTLE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stim   = stim_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.tt_out = tt_q;

`ifdef TT_EXPECT_CHECK_EN
    logic [N_OUT-1:0] exp_sel;
    logic             mis_q;
    logic [N_IN-1:0]  mis_idx_q;

    for (genvar o = 0; o < N_OUT; o++) begin : g_exp
        logic [C-1:0] exp_row;
        assign exp_row    = bus.exp_tt[tt_bit(o, 0, N_IN) +: C];
        assign exp_sel[o] = exp_row[index[N_IN-1:0]];
    end

    // Sticky: only the first differing index is kept until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mis_q     <= 1'b0;
            mis_idx_q <= '0;
        end else if (accept) begin
            mis_q     <= 1'b0;
            mis_idx_q <= '0;
        end else if ((state == SAMPLE) && !mis_q && (|(exp_sel ^ bus.resp))) begin
            mis_q     <= 1'b1;
            mis_idx_q <= index[N_IN-1:0];
        end
    end

    assign bus.mismatch     = mis_q;
    assign bus.mismatch_idx = mis_idx_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: SETTLE_CYCLES=1 with a boolean UUT, SETTLE_CYCLES=3 with resp=stim.
module tb_truth_table_scanner;
    import tt_scan_pkg::*;

    localparam int unsigned N_IN  = 3;
    localparam int unsigned N_OUT = 3;
    localparam int unsigned TT_W  = 24;

    typedef struct {
        logic [TT_W-1:0] tt;
        int unsigned     lat;
        logic            mis;
        logic [2:0]      mis_idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n    = 1'b0;
    logic start    = 1'b0;
    logic sel      = 1'b0;
    logic force_f2 = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        sb[$];

    truth_table_scanner_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if1 ();
    truth_table_scanner_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if3 ();

    logic a, b, c;
    assign a = if1.stim[2];
    assign b = if1.stim[1];
    assign c = if1.stim[0];

    assign if1.start = start & ~sel;
    assign if3.start = start & sel;
    assign if1.resp  = {(a ^ b) & c, force_f2 | (~a & ~b) | (b & c), (a & b) | (~a & c)};
    assign if3.resp  = if3.stim;

`ifdef TT_EXPECT_CHECK_EN
    logic [TT_W-1:0] exp_tt_v = 24'h288BCA;
    assign if1.exp_tt = exp_tt_v;
    assign if3.exp_tt = 24'hF0CCAA;
`endif

    truth_table_scanner #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1)
    );

    truth_table_scanner #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(3)) u_dut3 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if3)
    );

    logic [2:0]      o_stim;
    logic            o_busy, o_done;
    logic [TT_W-1:0] o_tt;
    assign o_stim = sel ? if3.stim   : if1.stim;
    assign o_busy = sel ? if3.busy   : if1.busy;
    assign o_done = sel ? if3.done   : if1.done;
    assign o_tt   = sel ? if3.tt_out : if1.tt_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic sweep(input logic [TT_W-1:0] tt, input int unsigned lat, input bit log_stim,
                         input bit mid_start, input logic mis, input logic [2:0] mis_idx);
        exp_t        e;
        int unsigned n;
        int unsigned k;
        bit          pulsed;
        e.tt      = tt;
        e.lat     = lat;
        e.mis     = mis;
        e.mis_idx = mis_idx;
        sb.push_back(e);

        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        pulsed = 1'b0;
        check("accept_busy", 32'(o_busy), 32'd1);
        check("accept_tt_clr", 32'(o_tt), 32'd0);
        if (log_stim) check("stim_0", 32'(o_stim), 32'd0);

        while (o_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            #1 start = 1'b0;
            k = (n - 1) / 2;
            if (k > 7) k = 7;
            if (log_stim) check($sformatf("stim_e%0d", n - 1), 32'(o_stim), k);
            if (mid_start && !pulsed && o_stim == 3'd4) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end

        if (o_done !== 1'b1) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("tt_out", 32'(o_tt), 32'(e.tt));
`ifdef TT_EXPECT_CHECK_EN
        if (!sel) begin
            check("mismatch", 32'(if1.mismatch), 32'(e.mis));
            check("mismatch_idx", 32'(if1.mismatch_idx), 32'(e.mis_idx));
        end
`endif
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(o_busy), 32'd0);
        check("done_pulse", 32'(o_done), 32'd0);
        check("stim_hold", 32'(o_stim), 32'd7);
        check("tt_hold", 32'(o_tt), 32'(e.tt));
    endtask

    initial begin
        int unsigned n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stim", 32'(if1.stim), 32'd0);
        check("rst_busy", 32'(if1.busy), 32'd0);
        check("rst_done", 32'(if1.done), 32'd0);
        check("rst_tt", 32'(if1.tt_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Plain sweep, then a back-to-back sweep with a start pulse ignored mid-sweep.
        sweep(24'h288BCA, 17, 1'b1, 1'b0, 1'b0, 3'd0);
        sweep(24'h288BCA, 17, 1'b0, 1'b1, 1'b0, 3'd0);

        // Reset while sweeping index 5.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (o_stim != 3'd5 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("reach_idx5", 32'(o_stim), 32'd5);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_stim", 32'(o_stim), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_tt", 32'(o_tt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("midrst_idle", 32'(o_busy), 32'd0);
        sweep(24'h288BCA, 17, 1'b0, 1'b0, 1'b0, 3'd0);

`ifdef TT_EXPECT_CHECK_EN
        force_f2 = 1'b1;
        sweep(24'h28FFCA, 17, 1'b0, 1'b0, 1'b1, 3'd2);
        force_f2 = 1'b0;
        sweep(24'h288BCA, 17, 1'b0, 1'b0, 1'b0, 3'd0);
`endif

        sel = 1'b1;
        sweep(24'hF0CCAA, 33, 1'b0, 1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
